// File: rtl/score_pkg.sv
// Shared constants for the multi-channel score counter: default count
// geometry and the saturate/wrap policy encodings.
package score_pkg;

  localparam int DEF_BW      = 7;
  localparam int DEF_MAX_VAL = 99;

  localparam int MODE_SAT    = 0;
  localparam int MODE_WRAP   = 1;

endpackage

// File: rtl/btn_edge_sync.sv
// One asynchronous button: SYNC_STAGES-deep synchroniser followed by a
// previous-value flop; rise_o pulses for one cycle per rising level.
module btn_edge_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic btn_i,
  output logic rise_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], btn_i};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign rise_o = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/score_counter_mc.sv
// N_CH independent up/down score counters fed by synchronised, edge-detected
// buttons, with per-channel clear, global hold, limit pulses and an all-equal flag.
module score_counter_mc
  import score_pkg::*;
#(
  parameter int N_CH        = 2,
  parameter int BW          = DEF_BW,
  parameter int MAX_VAL     = DEF_MAX_VAL,
  parameter int WRAP        = MODE_SAT,
  parameter int SYNC_STAGES = 2
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic [N_CH-1:0]    up_i,
  input  logic [N_CH-1:0]    down_i,
  input  logic [N_CH-1:0]    clr_i,
  input  logic               hold_i,
  output logic [N_CH*BW-1:0] count_o,
  output logic [N_CH-1:0]    limit_o,
  output logic               eq_o
);

  if (N_CH < 1 || SYNC_STAGES < 2 || BW < 1 || MAX_VAL < 0 ||
      longint'(MAX_VAL) >= (longint'(1) << BW)) begin : g_param_check
    $fatal(1, "score_counter_mc: illegal parameters N_CH=%0d BW=%0d MAX_VAL=%0d SYNC_STAGES=%0d",
           N_CH, BW, MAX_VAL, SYNC_STAGES);
  end

  localparam logic [BW-1:0] MAX_C = BW'(MAX_VAL);
  localparam logic [BW-1:0] ONE_C = BW'(1);

  logic [N_CH-1:0] up_rise;
  logic [N_CH-1:0] dn_rise;

  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    logic [BW-1:0] cnt_q, cnt_d;
    logic          limit_q, limit_d;

    btn_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_up (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .btn_i  (up_i[c]),
      .rise_o (up_rise[c])
    );

    btn_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_dn (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .btn_i  (down_i[c]),
      .rise_o (dn_rise[c])
    );

    // Bounds are checked before the step, so the BW-bit add/sub never overflows.
    always_comb begin
      cnt_d   = cnt_q;
      limit_d = 1'b0;
      if (clr_i[c]) begin
        cnt_d = '0;
      end else if (!hold_i && (up_rise[c] != dn_rise[c])) begin
        if (up_rise[c]) begin
          if (cnt_q < MAX_C) begin
            cnt_d = cnt_q + ONE_C;
          end else begin
            limit_d = 1'b1;
            cnt_d   = (WRAP == MODE_WRAP) ? '0 : MAX_C;
          end
        end else begin
          if (cnt_q > '0) begin
            cnt_d = cnt_q - ONE_C;
          end else begin
            limit_d = 1'b1;
            cnt_d   = (WRAP == MODE_WRAP) ? MAX_C : '0;
          end
        end
      end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        cnt_q   <= '0;
        limit_q <= 1'b0;
      end else begin
        cnt_q   <= cnt_d;
        limit_q <= limit_d;
      end
    end

    assign count_o[c*BW +: BW] = cnt_q;
    assign limit_o[c]          = limit_q;
  end

  always_comb begin
    eq_o = 1'b1;
    for (int c = 1; c < N_CH; c++) begin
      if (count_o[c*BW +: BW] != count_o[0 +: BW]) eq_o = 1'b0;
    end
  end

endmodule

// File: tb/tb_score_counter_mc.sv
// Bench for score_counter_mc: a saturating and a wrapping instance share stimulus
// and are checked every cycle against a sample-history model plus literal expectations.
module tb_score_counter_mc;
  localparam int MAXV = 99;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  up = '0, down = '0, clr = '0;
  logic        hold = 1'b0;

  logic [13:0] cnt_s, cnt_w;
  logic [1:0]  lim_s, lim_w;
  logic        eq_s, eq_w;

  int n_checks = 0;
  int n_pass   = 0;
  bit cmp_en   = 1'b0;

  always #5 clk = ~clk;

  score_counter_mc #(.N_CH(2), .BW(7), .MAX_VAL(MAXV), .WRAP(0), .SYNC_STAGES(2)) dut_sat (
    .clk_i(clk), .rst_ni(rst_n), .up_i(up), .down_i(down), .clr_i(clr), .hold_i(hold),
    .count_o(cnt_s), .limit_o(lim_s), .eq_o(eq_s));

  score_counter_mc #(.N_CH(2), .BW(7), .MAX_VAL(MAXV), .WRAP(1), .SYNC_STAGES(2)) dut_wrap (
    .clk_i(clk), .rst_ni(rst_n), .up_i(up), .down_i(down), .clr_i(clr), .hold_i(hold),
    .count_o(cnt_w), .limit_o(lim_w), .eq_o(eq_w));

  task automatic check(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    else n_pass++;
  endtask

  // Model: a button level sampled at edge k takes effect at edge k+2 if the
  // level sampled at edge k-1 was low. hu/hd hold the last three samples.
  int m_cnt [2][2];   // [dut: 0 sat, 1 wrap][channel]
  bit m_lim [2][2];
  bit hu [2][3];
  bit hd [2][3];
  bit ue, de;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int d = 0; d < 2; d++)
        for (int c = 0; c < 2; c++) begin
          m_cnt[d][c] = 0; m_lim[d][c] = 0;
        end
      for (int c = 0; c < 2; c++)
        for (int k = 0; k < 3; k++) begin
          hu[c][k] = 0; hd[c][k] = 0;
        end
    end else begin
      for (int c = 0; c < 2; c++) begin
        ue = hu[c][1] && !hu[c][2];
        de = hd[c][1] && !hd[c][2];
        hu[c][2] = hu[c][1]; hu[c][1] = hu[c][0]; hu[c][0] = up[c];
        hd[c][2] = hd[c][1]; hd[c][1] = hd[c][0]; hd[c][0] = down[c];
        for (int d = 0; d < 2; d++) begin
          m_lim[d][c] = 0;
          if (clr[c]) m_cnt[d][c] = 0;
          else if (!hold && ue && !de) begin
            if (m_cnt[d][c] < MAXV) m_cnt[d][c] = m_cnt[d][c] + 1;
            else begin m_lim[d][c] = 1; m_cnt[d][c] = (d == 1) ? 0 : MAXV; end
          end else if (!hold && de && !ue) begin
            if (m_cnt[d][c] > 0) m_cnt[d][c] = m_cnt[d][c] - 1;
            else begin m_lim[d][c] = 1; m_cnt[d][c] = (d == 1) ? MAXV : 0; end
          end
        end
      end
    end
  end

  int lc_s [2];
  int lc_w [2];

  always @(negedge clk) begin
    for (int c = 0; c < 2; c++) begin
      if (lim_s[c]) lc_s[c]++;
      if (lim_w[c]) lc_w[c]++;
    end
    if (cmp_en) begin
      for (int c = 0; c < 2; c++) begin
        check("model_cnt_sat",  int'(cnt_s[c*7 +: 7]), m_cnt[0][c]);
        check("model_cnt_wrap", int'(cnt_w[c*7 +: 7]), m_cnt[1][c]);
        check("model_lim_sat",  int'(lim_s[c]), int'(m_lim[0][c]));
        check("model_lim_wrap", int'(lim_w[c]), int'(m_lim[1][c]));
      end
      check("model_eq_sat",  int'(eq_s), int'(m_cnt[0][0] == m_cnt[0][1]));
      check("model_eq_wrap", int'(eq_w), int'(m_cnt[1][0] == m_cnt[1][1]));
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse(input logic [1:0] um, input logic [1:0] dm, input int hi, input int lo);
    up = up | um; down = down | dm;
    cyc(hi);
    up = up & ~um; down = down & ~dm;
    cyc(lo);
  endtask

  task automatic pulses(input logic [1:0] um, input int n);
    for (int i = 0; i < n; i++) pulse(um, 2'b00, 2, 2);
    cyc(2);
  endtask

  int l0, l1;

  initial begin
    cyc(2);
    rst_n = 1'b1;
    cyc(1);
    cmp_en = 1'b1;
    check("reset_cnt", int'(cnt_s), 0);
    check("reset_eq",  int'(eq_s), 1);
    check("reset_lim", int'(lim_s), 0);

    // ch0 five pulses, with latency pinned on the first
    up[0] = 1'b1;
    cyc(1);
    cyc(1); check("latency_e1", int'(cnt_s[6:0]), 0);
    cyc(1); check("latency_e2", int'(cnt_s[6:0]), 1);
    cyc(1);
    up[0] = 1'b0; cyc(4);
    for (int i = 0; i < 4; i++) pulse(2'b01, 2'b00, 4, 4);
    check("five_ch0", int'(cnt_s[6:0]), 5);
    check("five_ch1", int'(cnt_s[13:7]), 0);
    check("five_eq",  int'(eq_s), 0);

    // ch1 to the top limit, then over it
    pulses(2'b10, 99);
    check("ch1_99_sat",  int'(cnt_s[13:7]), 99);
    check("ch1_99_wrap", int'(cnt_w[13:7]), 99);
    l0 = lc_s[1]; l1 = lc_w[1];
    pulses(2'b10, 1);
    check("sat_top_cnt",  int'(cnt_s[13:7]), 99);
    check("wrap_top_cnt", int'(cnt_w[13:7]), 0);
    check("sat_top_lim",  lc_s[1] - l0, 1);
    check("wrap_top_lim", lc_w[1] - l1, 1);

    // down at zero
    clr = 2'b10; cyc(1); clr = 2'b00; cyc(1);
    l0 = lc_s[1]; l1 = lc_w[1];
    pulse(2'b00, 2'b10, 2, 2); cyc(2);
    check("sat_bot_cnt",  int'(cnt_s[13:7]), 0);
    check("wrap_bot_cnt", int'(cnt_w[13:7]), 99);
    check("sat_bot_lim",  lc_s[1] - l0, 1);
    check("wrap_bot_lim", lc_w[1] - l1, 1);

    // simultaneous up/down at 10, then a long held level
    clr = 2'b11; cyc(1); clr = 2'b00; cyc(1);
    pulses(2'b01, 10);
    check("ch0_10", int'(cnt_s[6:0]), 10);
    l0 = lc_s[0]; l1 = lc_w[0];
    pulse(2'b01, 2'b01, 2, 2); cyc(2);
    check("both_edges_cnt", int'(cnt_s[6:0]), 10);
    check("both_edges_lim", (lc_s[0] - l0) + (lc_w[0] - l1), 0);
    pulse(2'b01, 2'b00, 50, 4);
    check("held_50", int'(cnt_s[6:0]), 11);

    // hold discards edges
    hold = 1'b1;
    for (int i = 0; i < 3; i++) pulse(2'b01, 2'b00, 2, 2);
    cyc(2);
    hold = 1'b0;
    cyc(6);
    check("hold_cnt", int'(cnt_s[6:0]), 11);

    // clear beats a coincident up edge on ch1 at 42
    pulses(2'b10, 42);
    check("ch1_42", int'(cnt_w[13:7]), 42);
    up[1] = 1'b1;
    cyc(2);
    clr[1] = 1'b1;
    cyc(1);
    clr[1] = 1'b0;
    check("clr_vs_up", int'(cnt_s[13:7]), 0);
    cyc(1); up[1] = 1'b0; cyc(4);
    check("clr_discard", int'(cnt_s[13:7]), 0);

    // 7/7 then asynchronous reset mid-cycle, button held across release
    clr = 2'b11; cyc(1); clr = 2'b00; cyc(1);
    pulses(2'b11, 7);
    check("both_7", int'(cnt_s), (7 << 7) | 7);
    check("both_7_eq", int'(eq_w), 1);
    up[0] = 1'b1;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("arst_cnt_sat",  int'(cnt_s), 0);
    check("arst_cnt_wrap", int'(cnt_w), 0);
    check("arst_eq",       int'(eq_s), 1);
    check("arst_lim",      int'(lim_s | lim_w), 0);
    cyc(3);
    @(posedge clk); #3;
    rst_n = 1'b1;
    cyc(6);
    check("held_release_ch0", int'(cnt_s[6:0]), 1);
    check("held_release_ch1", int'(cnt_s[13:7]), 0);
    up[0] = 1'b0;
    cyc(4);
    check("held_release_once", int'(cnt_w[6:0]), 1);

    cmp_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/score_counter_mc.md
Name: score_counter_mc

Overview:
Multi-channel up/down score counter, the parametrised successor of the single-channel scoreboard counter. Each channel counts rising edges on asynchronous up/down button inputs. Every input is synchronised and edge-detected inside the block. Each channel holds a count in 0..MAX_VAL, with a per-instance saturate-or-wrap policy, per-channel clear, global hold, and event flags. It sits between the button/debounce front end and the display/BCD conversion logic.

Parameters:
N_CH, 2, number of independent channels (teams); must be >= 1
BW, 7, count width per channel in bits
MAX_VAL, 99, upper count limit; must satisfy MAX_VAL < 2**BW
WRAP, 0, 0 = saturate at 0 and MAX_VAL; 1 = wrap MAX_VAL->0 and 0->MAX_VAL
SYNC_STAGES, 2, synchroniser flops per button input; must be >= 2

Ports:
clk_i  in  1  single system clock; all logic on posedge
rst_ni  in  1  asynchronous active-low reset
up_i  in  N_CH  per-channel count-up buttons, asynchronous
down_i  in  N_CH  per-channel count-down buttons, asynchronous
clr_i  in  N_CH  per-channel synchronous clear to 0, active-high, already synchronous to clk_i
hold_i  in  1  freeze all counts while high; synchronous
count_o  out  N_CH*BW  packed counts, channel c at [c*BW +: BW]
limit_o  out  N_CH  one-cycle pulse: the channel hit a limit (saturation attempt or wrap)
eq_o  out  1  high when all channel counts are equal; always 1 when N_CH = 1

Behaviour:
- Reset (rst_ni low, asynchronous): all counts = 0, limit_o = 0, all synchroniser and previous-value flops = 0, so eq_o = 1.
- Input path per button: SYNC_STAGES flop synchroniser -> prev flop.
  - edge = sync_out & ~prev.
  - One count step per rising edge; a held level never repeats.
- Latency with SYNC_STAGES = 2: a button first sampled high at edge E0 updates count_o at edge E2 (visible after E2).
  - A button held high across reset release counts once after release (prev resets to 0).
- Per-channel priority per cycle, highest first:
  1. clr_i: count <= 0, limit_o = 0, pending edges discarded.
  2. hold_i: count unchanged, edges discarded (not queued); the edge detector keeps tracking.
  3. up_edge & down_edge together: no change, no limit pulse.
  4. up_edge alone: if count < MAX_VAL, count + 1. Else WRAP=0 -> stay at MAX_VAL, limit pulse; WRAP=1 -> 0, limit pulse.
  5. down_edge alone: if count > 0, count - 1. Else WRAP=0 -> stay at 0, limit pulse; WRAP=1 -> MAX_VAL, limit pulse.
- limit_o is registered. It is high for exactly the one cycle after the update edge (aligned with the new count_o) and is otherwise 0.
- Arithmetic is BW bits and unsigned. Counts never leave 0..MAX_VAL. No intermediate overflow is possible because the bounds are checked first.
- Channels are fully independent; there is no cross-channel interaction except eq_o.
- eq_o is combinational from the count registers, with no extra latency.
- Reset mid-operation aborts everything immediately. Synchroniser contents are lost, and the next edge needs a fresh rising level.
- Parameter violations (MAX_VAL >= 2**BW, N_CH < 1, SYNC_STAGES < 2) must be caught by an elaboration-time check that stops elaboration.

Decomposition:
- Shared package score_pkg:
  - default BW and MAX_VAL constants (7, 99)
  - WRAP mode constants MODE_SAT = 0, MODE_WRAP = 1
- Sub-module btn_edge_sync: one button, SYNC_STAGES synchroniser plus rising-edge pulse, async active-low reset.
  - Instantiated 2*N_CH times via generate.
- The counter update for each channel is a generate loop inside score_counter_mc; no further sub-modules.

Test Plan:
- Reset, then up_i[0] pulsed 5 times (4 cycles high / 4 low each) -> count ch0 = 5, ch1 = 0, eq_o = 0; first change exactly 2 edges after first high sample.
- WRAP=0: ch1 driven to 99, one more up pulse -> stays 99, limit_o[1] high 1 cycle; down at 0 -> stays 0, limit pulse.
- WRAP=1: ch0 at 99 plus up -> 0 with limit pulse; 0 plus down -> 99 with limit pulse.
- up_i[0] and down_i[0] rising in the same cycle at count 10 -> stays 10, no limit pulse; up held high 50 cycles -> exactly +1.
- hold_i high during 3 up pulses -> no change, nothing counted after hold drops; clr_i[1] with simultaneous up edge at count 42 -> 0.
- rst_ni asserted asynchronously mid-clock at counts 7/7 -> immediate 0/0, eq_o = 1, limit_o = 0; button held across release -> exactly one count after release.
